encoder_drain_nto_log2: RTL and testbench

//  Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes.
//  - Accepts an N-bit request vector.
//  - Serialises every set bit into a stream of binary indices, one per output transfer,
//    in priority order.
//  - Successor to the combinational 8-to-3 one-hot encoder: multi-hot input is drained,
//    not treated as don't-care.
//  - Sits between request collectors (IRQ/event lines) and index-consuming logic.

---
 rtl/encoder_drain_nto_log2.sv | 130 +++++++++++++
 tb/tb_encoder_drain_nto_log2.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_drain_nto_log2.sv
// Purpose: registered N-to-log2(N) priority encoder; drains every set bit of a request vector as a stream of indices.
// Latency: first index valid the cycle after the vector is accepted, then one index per cycle while out_ready is high.
// Backpressure: out_ready low holds index/last/pend stable; in_ready only opens in IDLE or on the final transfer.
// Optional feature: define ENC_ONEHOT_CHECK_EN to add err_pulse/err_cnt reporting of non-one-hot input vectors.
module encoder_drain_nto_log2 #(
   parameter int N         = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy
`ifdef ENC_ONEHOT_CHECK_EN
   ,
   output logic                 err_pulse,
   output logic [7:0]           err_cnt
`endif
);

   localparam int W = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   pend, pend_nxt;
   logic [W-1:0]   sel_idx;
   logic           pend_single;
   logic           in_accept;
   logic           out_xfer;
   logic           vec_nonzero;

   // Priority pick over pend: the last match in scan order wins, so scan away from the preferred end.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (MSB_FIRST != 0) begin
            if (pend[i]) sel_idx = W'(i);
         end else begin
            if (pend[N-1-i]) sel_idx = W'(N-1-i);
         end
      end
   end

   // Exactly one bit pending means the current index is the last one of this vector.
   assign pend_single = (pend != '0) && ((pend & (pend - 1'b1)) == '0);
   assign vec_nonzero = (in_vec != '0);

   // Outputs decode purely from registered state; in_ready is the only path from out_ready.
   always_comb begin
      out_valid = (state == DRAIN);
      out_idx   = (state == DRAIN) ? sel_idx : '0;
      out_last  = (state == DRAIN) && pend_single;
      busy      = (state == DRAIN);
      in_ready  = (state == IDLE) ? 1'b1 : (out_last && out_ready);
   end

   assign in_accept = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Next-state and pending-bit update; a final transfer may hand straight over to a new vector.
   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      case (state)
         IDLE: begin
            if (in_accept && vec_nonzero) begin
               pend_nxt  = in_vec;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (out_xfer) begin
               pend_nxt[sel_idx] = 1'b0;
               if (out_last) begin
                  if (in_accept && vec_nonzero) begin
                     pend_nxt  = in_vec;
                     state_nxt = DRAIN;
                  end else begin
                     pend_nxt  = '0;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            pend_nxt  = '0;
         end
      endcase
   end

   // State and pending register; reset discards anything still being drained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

`ifdef ENC_ONEHOT_CHECK_EN
   logic vec_onehot;
   assign vec_onehot = vec_nonzero && ((in_vec & (in_vec - 1'b1)) == '0);

   // Flag each accepted vector that is zero or multi-hot; the counter sticks at 255.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_pulse <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         err_pulse <= in_accept && !vec_onehot;
         if (in_accept && !vec_onehot && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_encoder_drain_nto_log2.sv
// Bench for encoder_drain_nto_log2: directed steps with hand-computed expectations.
// Two instances (LSB-first and MSB-first) share inputs; the MSB-first one is checked on the multi-hot drain.
// Inputs change #1 after the rising edge; outputs are checked at that point, away from the edge.
module tb_encoder_drain_nto_log2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_vec;
   logic       out_ready;

   logic       in_ready, out_valid, out_last, busy;
   logic [2:0] out_idx;
   logic       m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [2:0] m_out_idx;
`ifdef ENC_ONEHOT_CHECK_EN
   logic       err_pulse, m_err_pulse;
   logic [7:0] err_cnt, m_err_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   encoder_drain_nto_log2 #(.N(8), .MSB_FIRST(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
      .busy(busy)
`ifdef ENC_ONEHOT_CHECK_EN
      , .err_pulse(err_pulse), .err_cnt(err_cnt)
`endif
   );

   encoder_drain_nto_log2 #(.N(8), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx), .out_last(m_out_last),
      .busy(m_busy)
`ifdef ENC_ONEHOT_CHECK_EN
      , .err_pulse(m_err_pulse), .err_cnt(m_err_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the LSB-first output triple in one call.
   task automatic chk_out(input string tag, input logic v, input logic [2:0] idx, input logic last);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".idx"},   {29'd0, out_idx},   {29'd0, idx});
      chk({tag, ".last"},  {31'd0, out_last},  {31'd0, last});
   endtask

   task automatic chk_msb(input string tag, input logic [2:0] idx, input logic last);
      chk({tag, ".msb_idx"},  {29'd0, m_out_idx},  {29'd0, idx});
      chk({tag, ".msb_last"}, {31'd0, m_out_last}, {31'd0, last});
   endtask

   initial begin
      // 1. Reset held with a full vector offered
      rst_n = 1'b0; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
      tick(); tick();
      chk_out("rst", 1'b0, 3'd0, 1'b0);
      chk("rst.busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1; in_valid = 1'b0; #1;
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

      // 2. One-hot vectors back-to-back
      in_valid = 1'b1; in_vec = 8'h01;
      tick();
      chk_out("oh0", 1'b1, 3'd0, 1'b1);
      in_vec = 8'h80; #1;
      chk("oh0.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("oh7", 1'b1, 3'd7, 1'b1);
      in_vec = 8'h20; #1;
      chk("oh7.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("oh5", 1'b1, 3'd5, 1'b1);
      in_valid = 1'b0;
      tick();
      chk_out("oh.done", 1'b0, 3'd0, 1'b0);
      chk("oh.busy", {31'd0, busy}, 32'd0);

      // 3. Multi-hot drain 1010_0110 in both priority orders
      in_valid = 1'b1; in_vec = 8'b1010_0110;
      tick();
      in_valid = 1'b0;
      chk_out("mh.a", 1'b1, 3'd1, 1'b0); chk_msb("mh.a", 3'd7, 1'b0);
      chk("mh.msb_busy", {31'd0, m_busy}, 32'd1);
      tick();
      chk_out("mh.b", 1'b1, 3'd2, 1'b0); chk_msb("mh.b", 3'd5, 1'b0);
      tick();
      chk_out("mh.c", 1'b1, 3'd5, 1'b0); chk_msb("mh.c", 3'd2, 1'b0);
      tick();
      chk_out("mh.d", 1'b1, 3'd7, 1'b1); chk_msb("mh.d", 3'd1, 1'b1);
      chk("mh.msb_in_ready", {31'd0, m_in_ready}, 32'd1);
      tick();
      chk_out("mh.done", 1'b0, 3'd0, 1'b0);
      chk("mh.msb_valid", {31'd0, m_out_valid}, 32'd0);

      // 4. Back-pressure on 0x0C; a competing vector must be ignored while in_ready is low
      in_valid = 1'b1; in_vec = 8'h0C; out_ready = 1'b0;
      tick();
      in_vec = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         chk_out("bp.stall", 1'b1, 3'd2, 1'b0);
         chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1; #1;
      chk_out("bp.rel", 1'b1, 3'd2, 1'b0);
      chk("bp.rel_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      in_valid = 1'b0; #1;
      chk_out("bp.last", 1'b1, 3'd3, 1'b1);
      chk("bp.last_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("bp.done", 1'b0, 3'd0, 1'b0);

      // 5a. Zero vector is consumed with no output
      in_valid = 1'b1; in_vec = 8'h00;
      tick();
      in_valid = 1'b0;
      chk_out("zero", 1'b0, 3'd0, 1'b0);
      chk("zero.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("zero.busy", {31'd0, busy}, 32'd0);

      // 5b. Zero vector accepted on a final transfer drops back to IDLE
      in_valid = 1'b1; in_vec = 8'h40;
      tick();
      chk_out("b2b0.a", 1'b1, 3'd6, 1'b1);
      in_vec = 8'h00;
      tick();
      in_valid = 1'b0;
      chk_out("b2b0.b", 1'b0, 3'd0, 1'b0);

      // 5c. Reset in the middle of draining 0xF0
      in_valid = 1'b1; in_vec = 8'hF0;
      tick();
      in_valid = 1'b0;
      chk_out("mrst.a", 1'b1, 3'd4, 1'b0);
      tick();
      chk_out("mrst.b", 1'b1, 3'd5, 1'b0);
      rst_n = 1'b0;
      tick();
      chk_out("mrst.c", 1'b0, 3'd0, 1'b0);
      chk("mrst.busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("mrst.d", {31'd0, out_valid}, 32'd0);
      tick();
      chk("mrst.e", {31'd0, out_valid}, 32'd0);

`ifdef ENC_ONEHOT_CHECK_EN
      // 6. One-hot checker: 0x03 and 0x00 are errors, 0x10 is not
      chk("err.rst_cnt", {24'd0, err_cnt}, 32'd0);
      chk("err.rst_pulse", {31'd0, err_pulse}, 32'd0);
      in_valid = 1'b1; in_vec = 8'h03;
      tick();
      in_valid = 1'b0;
      chk("err.p03", {31'd0, err_pulse}, 32'd1);
      tick();
      chk("err.p03_off", {31'd0, err_pulse}, 32'd0);
      tick();
      in_valid = 1'b1; in_vec = 8'h00;
      tick();
      chk("err.p00", {31'd0, err_pulse}, 32'd1);
      in_vec = 8'h10;
      tick();
      in_valid = 1'b0;
      chk("err.p10", {31'd0, err_pulse}, 32'd0);
      tick();
      chk("err.cnt2", {24'd0, err_cnt}, 32'd2);
      in_valid = 1'b1; in_vec = 8'h00;
      repeat (300) tick();
      in_valid = 1'b0;
      tick();
      chk("err.sat", {24'd0, err_cnt}, 32'd255);
      chk("err.msb_sat", {24'd0, m_err_cnt}, 32'd255);
      chk("err.msb_pulse", {31'd0, m_err_pulse}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
